regfile_mp: RTL

//  Multi-port, parametrised general-purpose register file for the little-computer core.
//  - Provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
//  - Register 0 is optionally hardwired to zero.
//  - A sequencer clears every register, one per cycle, after reset or on request.
//  - Sits between decode (read addresses) and writeback (write ports); clearing is reported via busy.

---
 rtl/lc_regfile_pkg.sv | 17 +
 rtl/regfile_clr_seq.sv | 45 ++++
 rtl/regfile_mp.sv | 90 +++++++++
 3 files changed

// File: rtl/lc_regfile_pkg.sv
// Shared types and defaults for the little-computer register file.
// Optional build macro used by regfile_mp: REGFILE_BYPASS_EN.
package lc_regfile_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  localparam int RF_REG_WIDTH = 16;
  localparam int RF_NUM_REGS  = 8;
  localparam int RF_NUM_RD    = 3;
  localparam int RF_NUM_WR    = 2;
  localparam int RF_ZERO_REG  = 1;

  function automatic int rf_addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register address once after reset or on request.
// The state output doubles as a debug view of the FSM.
module regfile_clr_seq
  import lc_regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = rf_addr_w(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output rf_state_t     state,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  logic [AW-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
          end
        end
        RF_CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NUM_REGS - 1)) state <= RF_IDLE;
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads, sync writes, clear sweep via regfile_clr_seq.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted write data to the read ports.
module regfile_mp
  import lc_regfile_pkg::*;
#(
  parameter  int REG_WIDTH = RF_REG_WIDTH,
  parameter  int NUM_REGS  = RF_NUM_REGS,
  parameter  int NUM_RD    = RF_NUM_RD,
  parameter  int NUM_WR    = RF_NUM_WR,
  parameter  int ZERO_REG  = RF_ZERO_REG,
  localparam int AW        = rf_addr_w(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_req,
  input  logic [NUM_RD*AW-1:0]        rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*AW-1:0]        wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
  output logic                        busy,
  output logic                        wr_drop
);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  rf_state_t            state;
  logic                 seq_busy;
  logic                 clr_we;
  logic [AW-1:0]        clr_addr;
  logic [NUM_WR-1:0]    wr_acc;

  regfile_clr_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .state    (state),
    .busy     (seq_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign busy = seq_busy;

  // A write is accepted only in IDLE and never to a hardwired r0.
  always_comb begin
    wr_acc = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_acc[w] = wr_en[w] && (state == RF_IDLE) &&
                  !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
    end
  end

  // Ascending port order makes the highest-numbered port win a same-address conflict.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (rst) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_acc[w]) regs[wr_addr[w*AW +: AW]] <= wr_data[w*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) wr_drop <= 1'b0;
    else      wr_drop <= |(wr_en & ~wr_acc);
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [AW-1:0]        ra;
      logic [REG_WIDTH-1:0] rv;
      ra = rd_addr[p*AW +: AW];
      rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_acc[w] && (wr_addr[w*AW +: AW] == ra)) rv = wr_data[w*REG_WIDTH +: REG_WIDTH];
      end
`else
`endif
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
      rd_data[p*REG_WIDTH +: REG_WIDTH] = rv;
    end
  end

endmodule
